// File: rtl/cpu_pkg.sv
// Shared types and opcode map for the ExceptioNull CPU control path.
package cpu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned ADDR_W = 8;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_FETCH  = 3'd1,
    SEQ_DECODE = 3'd2,
    SEQ_EXEC   = 3'd3,
    SEQ_MEM    = 3'd4,
    SEQ_WB     = 3'd5,
    SEQ_HALT   = 3'd6,
    SEQ_FAULT  = 3'd7
  } seq_state_t;

  localparam logic [OP_W-1:0] OP_LOAD   = 4'h8;
  localparam logic [OP_W-1:0] OP_STORE  = 4'h9;
  localparam logic [OP_W-1:0] OP_BRANCH = 4'hA;
  localparam logic [OP_W-1:0] OP_JUMP   = 4'hB;
  localparam logic [OP_W-1:0] OP_PUSH   = 4'hC;
  localparam logic [OP_W-1:0] OP_POP    = 4'hD;
  localparam logic [OP_W-1:0] OP_NOP    = 4'hE;
  localparam logic [OP_W-1:0] OP_HALT   = 4'hF;

  // Enable strobes and status flags driven by the sequencer each cycle.
  typedef struct packed {
    logic ir_load;
    logic reg_w_en;
    logic mem_r_en;
    logic mem_w_en;
    logic stack_w_en;
    logic stack_r_en;
    logic halted;
    logic fault;
  } seq_strobe_t;

  // Opcodes 0x0-0x7 are the ALU class.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return !op[OP_W-1];
  endfunction

endpackage

// File: rtl/cpu_sequencer_stack_pointer.sv
// Hardware stack pointer: occupancy counter with full/empty flags.
module stack_pointer #(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                        full_c,
  output logic                        empty_c
);

  localparam int unsigned SP_W = $clog2(STACK_DEPTH) + 1;

  assign full_c  = (sp == SP_W'(STACK_DEPTH));
  assign empty_c = (sp == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !pop && !full_c) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !push && !empty_c) begin
      sp <= sp - SP_W'(1);
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: owns pc and the stack pointer and
// steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [OP_W-1:0]             opcode,
  input  logic                        branch_cond,
  input  logic [ADDR_W-1:0]           branch_target,
  input  logic                        mem_ready,
  output logic [ADDR_W-1:0]           pc,
  output logic                        ir_load,
  output logic                        reg_w_en,
  output logic                        mem_r_en,
  output logic                        mem_w_en,
  output logic                        stack_w_en,
  output logic                        stack_r_en,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                        halted,
  output logic                        fault
);

  localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] IDLE   = 3'(SEQ_IDLE);
  localparam logic [2:0] FETCH  = 3'(SEQ_FETCH);
  localparam logic [2:0] DECODE = 3'(SEQ_DECODE);
  localparam logic [2:0] EXEC   = 3'(SEQ_EXEC);
  localparam logic [2:0] MEM    = 3'(SEQ_MEM);
  localparam logic [2:0] WB     = 3'(SEQ_WB);
  localparam logic [2:0] HALT   = 3'(SEQ_HALT);
  localparam logic [2:0] FAULT  = 3'(SEQ_FAULT);

  logic [2:0]        state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] pc_d;
  logic [TMO_W-1:0]  mem_cnt_q, mem_cnt_d;
  seq_strobe_t       strb_q, strb_d;
  logic              sp_full_c, sp_empty_c;

  // Next state, latched opcode, pc and MEM wait counter.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    pc_d      = pc;
    mem_cnt_d = mem_cnt_q;
    case (state_q)
      IDLE:   if (start) state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: begin
        op_d    = opcode;
        state_d = EXEC;
      end
      EXEC: begin
        mem_cnt_d = '0;
        if (is_alu_op(op_q)) begin
          state_d = WB;
        end else begin
          case (op_q)
            OP_LOAD, OP_STORE: state_d = MEM;
            OP_PUSH:           state_d = sp_full_c ? FAULT : MEM;
            OP_POP:            state_d = sp_empty_c ? FAULT : MEM;
            OP_BRANCH: begin
              state_d = FETCH;
              pc_d    = branch_cond ? branch_target : pc + 8'd1;
            end
            OP_JUMP: begin
              state_d = FETCH;
              pc_d    = branch_target;
            end
            OP_HALT: state_d = HALT;
            default: begin
              state_d = FETCH;
              pc_d    = pc + 8'd1;
            end
          endcase
        end
      end
      MEM: begin
        case (op_q)
          OP_PUSH: begin
            state_d = FETCH;
            pc_d    = pc + 8'd1;
          end
          OP_POP: state_d = WB;
          default: begin
            // A ready in the final allowed cycle still completes the access.
            if (mem_ready) begin
              if (op_q == OP_LOAD) begin
                state_d = WB;
              end else begin
                state_d = FETCH;
                pc_d    = pc + 8'd1;
              end
            end else if (mem_cnt_q == TMO_W'(MEM_TIMEOUT - 1)) begin
              state_d = FAULT;
            end else begin
              mem_cnt_d = mem_cnt_q + TMO_W'(1);
            end
          end
        endcase
      end
      WB: begin
        state_d = FETCH;
        pc_d    = pc + 8'd1;
      end
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are a pure decode of the upcoming state, registered alongside it.
  always_comb begin
    strb_d = '0;
    case (state_d)
      FETCH: strb_d.ir_load = 1'b1;
      MEM: begin
        strb_d.mem_r_en   = (op_d == OP_LOAD);
        strb_d.mem_w_en   = (op_d == OP_STORE);
        strb_d.stack_w_en = (op_d == OP_PUSH);
        strb_d.stack_r_en = (op_d == OP_POP);
      end
      WB:   strb_d.reg_w_en = 1'b1;
      HALT: strb_d.halted = 1'b1;
      FAULT: begin
        strb_d.halted = 1'b1;
        strb_d.fault  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      pc        <= '0;
      mem_cnt_q <= '0;
      strb_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      pc        <= pc_d;
      mem_cnt_q <= mem_cnt_d;
      strb_q    <= strb_d;
    end
  end

  stack_pointer #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack_pointer (
    .clk     (clk),
    .rst     (rst),
    .push    (strb_q.stack_w_en),
    .pop     (strb_q.stack_r_en),
    .sp      (sp),
    .full_c  (sp_full_c),
    .empty_c (sp_empty_c)
  );

  assign ir_load    = strb_q.ir_load;
  assign reg_w_en   = strb_q.reg_w_en;
  assign mem_r_en   = strb_q.mem_r_en;
  assign mem_w_en   = strb_q.mem_w_en;
  assign stack_w_en = strb_q.stack_w_en;
  assign stack_r_en = strb_q.stack_r_en;
  assign halted     = strb_q.halted;
  assign fault      = strb_q.fault;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: per-instruction expectations from an
// instruction-level model, compared as the DUT moves to the next fetch or stops.
module tb_cpu_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       branch_cond = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic       mem_ready = 1'b0;
  logic [7:0] pc;
  logic       ir_load, reg_w_en, mem_r_en, mem_w_en, stack_w_en, stack_r_en;
  logic [2:0] sp;
  logic       halted, fault;

  cpu_sequencer #(.STACK_DEPTH(DEPTH), .MEM_TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .opcode        (opcode),
    .branch_cond   (branch_cond),
    .branch_target (branch_target),
    .mem_ready     (mem_ready),
    .pc            (pc),
    .ir_load       (ir_load),
    .reg_w_en      (reg_w_en),
    .mem_r_en      (mem_r_en),
    .mem_w_en      (mem_w_en),
    .stack_w_en    (stack_w_en),
    .stack_r_en    (stack_r_en),
    .sp            (sp),
    .halted        (halted),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  // n = MEM cycles until mem_ready for LOAD/STORE; 0 means never ready.
  typedef struct {
    logic [3:0] op;
    logic       cond;
    logic [7:0] tgt;
    int         n;
  } item_t;

  typedef struct {
    string name;
    int cycles, pc, sp, rd, wr, regw, push, pop, halted, fault;
  } exp_t;

  item_t prog_q[$];
  exp_t  exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    mpc = 0;
  int    msp = 0;
  int    issued = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Instruction-level reference: cycle count, strobe totals and end state.
  function automatic exp_t model(input item_t it);
    exp_t e;
    bit   ld, st, flt;
    int   op;
    op  = int'(it.op);
    ld  = (op == 8);
    st  = (op == 9);
    flt = (op == 12 && msp == DEPTH) || (op == 13 && msp == 0) ||
          ((ld || st) && it.n == 0);
    e.name   = $sformatf("i%0d_op%h", issued, it.op);
    e.rd     = ld ? (flt ? TMO : it.n) : 0;
    e.wr     = st ? (flt ? TMO : it.n) : 0;
    e.regw   = (op < 8 || ((ld || op == 13) && !flt)) ? 1 : 0;
    e.push   = (op == 12 && !flt) ? 1 : 0;
    e.pop    = (op == 13 && !flt) ? 1 : 0;
    e.halted = (op == 15 || flt) ? 1 : 0;
    e.fault  = flt ? 1 : 0;
    if (op < 8)                  e.cycles = 4;
    else if (ld)                 e.cycles = 4 + (flt ? TMO - 1 : it.n);
    else if (st)                 e.cycles = 3 + (flt ? TMO : it.n);
    else if (op == 12)           e.cycles = flt ? 3 : 4;
    else if (op == 13)           e.cycles = flt ? 3 : 5;
    else                         e.cycles = 3;
    if (op == 15 || flt)                   mpc = mpc;
    else if (op == 11 || (op == 10 && it.cond)) mpc = int'(it.tgt);
    else                                   mpc = (mpc + 1) % 256;
    msp  = msp + e.push - e.pop;
    e.pc = mpc;
    e.sp = msp;
    return e;
  endfunction

  // Driver: presents the next program item at each fetch; answers memory.
  item_t cur;
  int    mem_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      mem_cnt   = 0;
      mem_ready = 1'b0;
    end else begin
      if (ir_load) begin
        if (prog_q.size() > 0) begin
          cur = prog_q.pop_front();
          exp_q.push_back(model(cur));
          issued++;
        end else begin
          cur = '{op: 4'hF, cond: 1'b0, tgt: 8'h00, n: 1};
        end
        opcode        = cur.op;
        branch_cond   = cur.cond;
        branch_target = cur.tgt;
        mem_cnt       = 0;
      end
      if (mem_r_en || mem_w_en) begin
        mem_cnt++;
        mem_ready = (cur.n != 0 && mem_cnt == cur.n);
      end else begin
        mem_ready = 1'b0;
      end
    end
  end

  // Monitor: closes an instruction at the next fetch or when the DUT stops.
  bit   active = 0;
  logic prev_h = 1'b0;
  int   cyc, rd, wr, rw, pu, po;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      active = 0;
      prev_h = 1'b0;
    end else begin
      if (ir_load || (halted && !prev_h)) begin
        if (active) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check({e.name, ".cycles"}, cyc, e.cycles);
            check({e.name, ".pc"}, int'(pc), e.pc);
            check({e.name, ".sp"}, int'(sp), e.sp);
            check({e.name, ".mem_r_cycles"}, rd, e.rd);
            check({e.name, ".mem_w_cycles"}, wr, e.wr);
            check({e.name, ".reg_w"}, rw, e.regw);
            check({e.name, ".push"}, pu, e.push);
            check({e.name, ".pop"}, po, e.pop);
            check({e.name, ".halted"}, int'(halted), e.halted);
            check({e.name, ".fault"}, int'(fault), e.fault);
          end
        end
        active = ir_load;
        cyc = 0; rd = 0; wr = 0; rw = 0; pu = 0; po = 0;
      end
      prev_h = halted;
      if (active) begin
        cyc++;
        rd += int'(mem_r_en);
        wr += int'(mem_w_en);
        rw += int'(reg_w_en);
        pu += int'(stack_w_en);
        po += int'(stack_r_en);
      end
    end
  end

  task automatic do_reset(input bit with_start);
    int seen;
    @(negedge clk);
    rst   = 1'b1;
    start = with_start;
    @(negedge clk);
    check("rst.pc", int'(pc), 0);
    check("rst.sp", int'(sp), 0);
    check("rst.strobes", int'({ir_load, reg_w_en, mem_r_en, mem_w_en, stack_w_en, stack_r_en}), 0);
    check("rst.halted", int'(halted), 0);
    check("rst.fault", int'(fault), 0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    exp_q.delete();
    prog_q.delete();
    mpc = 0;
    msp = 0;
    if (with_start) begin
      seen = 0;
      repeat (3) begin
        @(negedge clk);
        seen += int'(ir_load);
      end
      check("start_with_rst.no_fetch", seen, 0);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic cond, input logic [7:0] tgt, input int n);
    prog_q.push_back('{op: op, cond: cond, tgt: tgt, n: n});
  endtask

  task automatic go();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
    check("halt_reached", int'(halted), 1);
    repeat (2) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
  endtask

  task automatic gen_random(input int count);
    int s;
    logic [3:0] op;
    s = 0;
    for (int i = 0; i < count; i++) begin
      op = 4'($urandom_range(0, 14));
      if ((op == 4'hC && s == DEPTH) || (op == 4'hD && s == 0)) op = 4'hE;
      if (op == 4'hC) s++;
      if (op == 4'hD) s--;
      add(op, 1'($urandom), 8'($urandom), int'($urandom_range(1, 4)));
    end
    add(4'hF, 1'b0, 8'h00, 1);
  endtask

  initial begin
    int seen;
    // Directed: ALU, delayed LOAD, branches, stack overflow.
    do_reset(1'b1);
    add(4'h3, 1'b0, 8'h00, 1);
    add(4'h8, 1'b0, 8'h00, 3);
    add(4'hA, 1'b1, 8'h40, 1);
    add(4'hA, 1'b0, 8'h40, 1);
    repeat (5) add(4'hC, 1'b0, 8'h00, 1);
    go();
    wait_halt();
    check("overflow.sp", int'(sp), 4);
    check("overflow.fault", int'(fault), 1);

    // Stack underflow.
    do_reset(1'b0);
    add(4'hD, 1'b0, 8'h00, 1);
    go();
    wait_halt();

    // pc wrap, then HALT ignores start.
    do_reset(1'b0);
    add(4'hB, 1'b0, 8'hFF, 1);
    add(4'hE, 1'b0, 8'h00, 1);
    add(4'h9, 1'b0, 8'h00, 1);
    add(4'hF, 1'b0, 8'h00, 1);
    go();
    wait_halt();
    start = 1'b1;
    seen  = 0;
    repeat (5) begin
      @(negedge clk);
      seen += int'(ir_load);
    end
    start = 1'b0;
    check("halt.pc_frozen", int'(pc), 1);
    check("halt.no_fetch", seen, 0);
    check("halt.fault_low", int'(fault), 0);

    // Memory never ready: timeout fault.
    do_reset(1'b0);
    add(4'hE, 1'b0, 8'h00, 1);
    add(4'hE, 1'b0, 8'h00, 1);
    add(4'h8, 1'b0, 8'h00, 0);
    go();
    wait_halt();

    // Reset while a LOAD waits in MEM.
    do_reset(1'b0);
    add(4'hE, 1'b0, 8'h00, 1);
    add(4'hE, 1'b0, 8'h00, 1);
    add(4'h8, 1'b0, 8'h00, 0);
    go();
    for (int i = 0; i < 50 && !mem_r_en; i++) @(negedge clk);
    check("mid_mem.reached", int'(mem_r_en), 1);
    repeat (2) @(negedge clk);
    check("mid_mem.pc_before", int'(pc), 2);
    do_reset(1'b0);
    check("mid_mem.rd_after", int'(mem_r_en), 0);

    // Random programs.
    for (int r = 0; r < 3; r++) begin
      do_reset(1'b0);
      gen_random(60);
      go();
      wait_halt();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
